// File: rtl/move_executor.sv
`default_nettype none
// ============================================================================
// Module  : move_executor
// Brief   : Turns one move request into the remove/place write sequence for
//           the board register file, with capture and pawn promotion.
// Revision: 1.0 - initial release
// ============================================================================
module move_executor #(
  parameter bit         PROMOTE_EN  = 1'b1,
  parameter logic [4:0] WHITE_QUEEN = 5'h05,
  parameter logic [4:0] BLACK_QUEEN = 5'h0B
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       move_valid,
  output logic       move_ready,
  input  logic [5:0] move_src,
  input  logic [5:0] move_dst,
  output logic [5:0] rd_pos,
  input  logic [4:0] rd_code,
  output logic [4:0] figure_code,
  output logic [5:0] figure_position,
  output logic       place_piece,
  output logic       remove_piece,
  output logic       move_done,
  output logic       move_err,
  output logic [1:0] err_code,
  output logic       captured_valid,
  output logic [4:0] captured_code
);

  localparam logic [3:0] c_IDLE    = 4'd0;
  localparam logic [3:0] c_RD_SRC  = 4'd1;
  localparam logic [3:0] c_RD_DST  = 4'd2;
  localparam logic [3:0] c_CHECK   = 4'd3;
  localparam logic [3:0] c_REM_SRC = 4'd4;
  localparam logic [3:0] c_REM_DST = 4'd5;
  localparam logic [3:0] c_PLACE   = 4'd6;
  localparam logic [3:0] c_DONE    = 4'd7;
  localparam logic [3:0] c_ERR     = 4'd8;

  localparam logic [4:0] c_EMPTY      = 5'd0;
  localparam logic [4:0] c_WHITE_PAWN = 5'd1;
  localparam logic [4:0] c_WHITE_MAX  = 5'd6;
  localparam logic [4:0] c_BLACK_PAWN = 5'd7;
  localparam logic [4:0] c_CODE_MAX   = 5'd12;

  logic [3:0] r_state;
  logic [3:0] w_next_state;
  logic [5:0] r_src;
  logic [5:0] r_dst;
  logic [4:0] r_src_code;
  logic [4:0] r_dst_code;
  logic [1:0] r_err_code;
  logic [4:0] r_captured_code;

  logic       w_accept;
  logic       w_src_bad;
  logic       w_dst_bad;
  logic       w_src_white;
  logic       w_dst_white;
  logic [1:0] w_check_err;
  logic [4:0] w_place_code;

  assign w_accept = move_valid && (r_state == c_IDLE);

  // In CHECK the destination code is judged straight off the read port,
  // the same cycle it is being latched.
  assign w_src_white = (r_src_code <= c_WHITE_MAX);
  assign w_dst_white = (rd_code <= c_WHITE_MAX);
  assign w_src_bad   = (r_src_code == c_EMPTY) || (r_src_code > c_CODE_MAX);
  assign w_dst_bad   = (rd_code > c_CODE_MAX) ||
                       ((rd_code != c_EMPTY) && (w_src_white == w_dst_white));

  always_comb begin
    w_check_err = 2'd0;
    if (r_src == r_dst)
      w_check_err = 2'd1;
    else if (w_src_bad)
      w_check_err = 2'd2;
    else if (w_dst_bad)
      w_check_err = 2'd3;
  end

  always_comb begin
    w_place_code = r_src_code;
    if (PROMOTE_EN && (r_src_code == c_WHITE_PAWN) && (r_dst[5:3] == 3'd0))
      w_place_code = WHITE_QUEEN;
    else if (PROMOTE_EN && (r_src_code == c_BLACK_PAWN) && (r_dst[5:3] == 3'd7))
      w_place_code = BLACK_QUEEN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= c_IDLE;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:    if (move_valid) w_next_state = c_RD_SRC;
      c_RD_SRC:  w_next_state = c_RD_DST;
      c_RD_DST:  w_next_state = c_CHECK;
      c_CHECK:   w_next_state = (w_check_err != 2'd0) ? c_ERR : c_REM_SRC;
      c_REM_SRC: w_next_state = (r_dst_code != c_EMPTY) ? c_REM_DST : c_PLACE;
      c_REM_DST: w_next_state = c_PLACE;
      c_PLACE:   w_next_state = c_DONE;
      c_DONE:    w_next_state = c_IDLE;
      c_ERR:     w_next_state = c_IDLE;
      default:   w_next_state = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src           <= 6'd0;
      r_dst           <= 6'd0;
      r_src_code      <= 5'd0;
      r_dst_code      <= 5'd0;
      r_err_code      <= 2'd0;
      r_captured_code <= 5'd0;
    end else begin
      if (w_accept) begin
        r_src           <= move_src;
        r_dst           <= move_dst;
        r_err_code      <= 2'd0;
        r_captured_code <= 5'd0;
      end
      if (r_state == c_RD_DST)
        r_src_code <= rd_code;
      if (r_state == c_CHECK) begin
        r_dst_code <= rd_code;
        r_err_code <= w_check_err;
      end
      if (r_state == c_PLACE)
        r_captured_code <= r_dst_code;
    end
  end

  always_comb begin
    move_ready      = 1'b0;
    rd_pos          = 6'd0;
    figure_code     = 5'd0;
    figure_position = 6'd0;
    place_piece     = 1'b0;
    remove_piece    = 1'b0;
    move_done       = 1'b0;
    move_err        = 1'b0;
    captured_valid  = 1'b0;
    case (r_state)
      c_IDLE:    move_ready = 1'b1;
      c_RD_SRC:  rd_pos = r_src;
      c_RD_DST:  rd_pos = r_dst;
      c_REM_SRC: begin
        remove_piece    = 1'b1;
        figure_position = r_src;
      end
      c_REM_DST: begin
        remove_piece    = 1'b1;
        figure_position = r_dst;
      end
      c_PLACE: begin
        place_piece     = 1'b1;
        figure_position = r_dst;
        figure_code     = w_place_code;
      end
      c_DONE: begin
        move_done      = 1'b1;
        captured_valid = (r_dst_code != c_EMPTY);
      end
      c_ERR:     move_err = 1'b1;
      default:   move_ready = 1'b0;
    endcase
  end

  assign err_code      = r_err_code;
  assign captured_code = r_captured_code;

endmodule
`default_nettype wire

// File: tb/tb_move_executor.sv
`default_nettype none
// ============================================================================
// Module  : tb_move_executor
// Brief   : Directed self-checking bench for move_executor.
// Revision: 1.0 - initial release
// ============================================================================
module tb_move_executor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       move_valid = 1'b0;
  logic [5:0] move_src = 6'd0;
  logic [5:0] move_dst = 6'd0;
  logic [4:0] rd_code = 5'd0;

  logic       move_ready, place_piece, remove_piece, move_done, move_err, captured_valid;
  logic [5:0] rd_pos, figure_position;
  logic [4:0] figure_code, captured_code;
  logic [1:0] err_code;

  logic       move_ready_np, place_piece_np, remove_piece_np, move_done_np, move_err_np, captured_valid_np;
  logic [5:0] rd_pos_np, figure_position_np;
  logic [4:0] figure_code_np, captured_code_np;
  logic [1:0] err_code_np;

  logic [4:0] board [64];

  int n_checks = 0;
  int n_pass   = 0;

  logic       s_rem [1:8];
  logic       s_plc [1:8];
  logic       s_done[1:8];
  logic       s_err [1:8];
  logic       s_cv  [1:8];
  logic [5:0] s_pos [1:8];
  logic [4:0] s_code[1:8];
  logic [4:0] s_code_np[1:8];
  int         n_strobes;
  int         n_overlap;

  always #5 clk = ~clk;

  // Board read port: one-cycle registered read
  always @(posedge clk) rd_code <= board[rd_pos];

  move_executor #(.PROMOTE_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .move_valid(move_valid), .move_ready(move_ready),
    .move_src(move_src), .move_dst(move_dst), .rd_pos(rd_pos), .rd_code(rd_code),
    .figure_code(figure_code), .figure_position(figure_position),
    .place_piece(place_piece), .remove_piece(remove_piece),
    .move_done(move_done), .move_err(move_err), .err_code(err_code),
    .captured_valid(captured_valid), .captured_code(captured_code)
  );

  move_executor #(.PROMOTE_EN(1'b0)) dut_np (
    .clk(clk), .rst(rst), .move_valid(move_valid), .move_ready(move_ready_np),
    .move_src(move_src), .move_dst(move_dst), .rd_pos(rd_pos_np), .rd_code(rd_code),
    .figure_code(figure_code_np), .figure_position(figure_position_np),
    .place_piece(place_piece_np), .remove_piece(remove_piece_np),
    .move_done(move_done_np), .move_err(move_err_np), .err_code(err_code_np),
    .captured_valid(captured_valid_np), .captured_code(captured_code_np)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_board();
    for (int i = 0; i < 64; i++) board[i] = 5'd0;
  endtask

  task automatic run_move(input logic [5:0] s, input logic [5:0] d);
    int waited;
    @(negedge clk);
    waited = 0;
    while (!move_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_val("ready_before_accept", move_ready, 1);
    move_src   = s;
    move_dst   = d;
    move_valid = 1'b1;
    @(posedge clk);
    #1 move_valid = 1'b0;
    n_strobes = 0;
    n_overlap = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      s_rem[k]     = remove_piece;
      s_plc[k]     = place_piece;
      s_done[k]    = move_done;
      s_err[k]     = move_err;
      s_cv[k]      = captured_valid;
      s_pos[k]     = figure_position;
      s_code[k]    = figure_code;
      s_code_np[k] = figure_code_np;
      n_strobes   += int'(remove_piece) + int'(place_piece);
      if (remove_piece && place_piece) n_overlap++;
    end
  endtask

  initial begin
    int waited;
    clear_board();

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_ready", move_ready, 1);
    check_val("rst_rd_pos", rd_pos, 0);
    check_val("rst_strobes", {place_piece, remove_piece, move_done, move_err, captured_valid}, 0);
    check_val("rst_fig", {figure_code, figure_position}, 0);
    check_val("rst_err_cap", {err_code, captured_code}, 0);
    rst = 1'b0;

    // Quiet move
    clear_board();
    board[6'o64] = 5'd1;
    run_move(6'o64, 6'o44);
    check_val("quiet_rem_t4", {s_rem[4], s_plc[4], s_pos[4], s_code[4]}, {2'b10, 6'o64, 5'd0});
    check_val("quiet_plc_t5", {s_rem[5], s_plc[5], s_pos[5], s_code[5]}, {2'b01, 6'o44, 5'd1});
    check_val("quiet_done_t6", {s_done[5], s_done[6], s_cv[6]}, 3'b010);
    check_val("quiet_strobes", n_strobes, 2);
    check_val("quiet_cap_code", captured_code, 0);

    // Capture
    clear_board();
    board[6'o44] = 5'd1;
    board[6'o13] = 5'd7;
    run_move(6'o44, 6'o13);
    check_val("cap_rem_src_t4", {s_rem[4], s_pos[4]}, {1'b1, 6'o44});
    check_val("cap_rem_dst_t5", {s_rem[5], s_plc[5], s_pos[5]}, {2'b10, 6'o13});
    check_val("cap_plc_t6", {s_plc[6], s_pos[6], s_code[6]}, {1'b1, 6'o13, 5'd1});
    check_val("cap_done_t7", {s_done[6], s_done[7], s_cv[7]}, 3'b011);
    check_val("cap_code_held", captured_code, 7);
    check_val("cap_overlap", n_overlap, 0);

    // Promotion, with and without PROMOTE_EN
    clear_board();
    board[6'o10] = 5'd1;
    run_move(6'o10, 6'o00);
    check_val("promo_plc", {s_plc[5], s_pos[5], s_code[5]}, {1'b1, 6'o00, 5'd5});
    check_val("promo_off_code", s_code_np[5], 1);
    check_val("promo_cap_cleared", captured_code, 0);

    // Black promotion
    clear_board();
    board[6'o61] = 5'd7;
    run_move(6'o61, 6'o71);
    check_val("bpromo_plc", {s_plc[5], s_code[5]}, {1'b1, 5'd11});

    // Error: src == dst
    clear_board();
    board[6'o33] = 5'd2;
    run_move(6'o33, 6'o33);
    check_val("err1_pulse", {s_err[3], s_err[4], s_err[5]}, 3'b010);
    check_val("err1_code", err_code, 1);
    check_val("err1_strobes", n_strobes, 0);

    // Error: source empty
    clear_board();
    run_move(6'o20, 6'o30);
    check_val("err2_pulse", s_err[4], 1);
    check_val("err2_code", err_code, 2);
    check_val("err2_strobes", n_strobes, 0);

    // Error: own colour at destination
    clear_board();
    board[6'o20] = 5'd1;
    board[6'o30] = 5'd4;
    run_move(6'o20, 6'o30);
    check_val("err3_pulse", s_err[4], 1);
    check_val("err3_code", err_code, 3);
    check_val("err3_strobes", n_strobes, 0);

    // Error: invalid destination code
    board[6'o30] = 5'd13;
    run_move(6'o20, 6'o30);
    check_val("err3_invalid_code", {s_err[4], err_code}, 3'b111);

    // Error: invalid source code
    clear_board();
    board[6'o20] = 5'd20;
    run_move(6'o20, 6'o30);
    check_val("err2_invalid_code", {s_err[4], err_code}, 3'b110);

    // Back-pressure: valid held across the whole first move
    clear_board();
    board[6'o64] = 5'd1;
    board[6'o52] = 5'd1;
    @(negedge clk);
    move_src   = 6'o64;
    move_dst   = 6'o44;
    move_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check_val($sformatf("bp_ready_low_t%0d", k), move_ready, 0);
      if (k == 6) check_val("bp_done_t6", move_done, 1);
    end
    move_src = 6'o52;
    move_dst = 6'o42;
    @(negedge clk);
    check_val("bp_ready_t7", move_ready, 1);
    @(negedge clk);
    check_val("bp_second_accept", {move_ready, rd_pos}, {1'b0, 6'o52});
    move_valid = 1'b0;
    waited = 0;
    while (!move_done && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_val("bp_second_done", move_done, 1);

    // Async reset while in REM_DST
    clear_board();
    board[6'o44] = 5'd1;
    board[6'o13] = 5'd7;
    @(negedge clk);
    move_src   = 6'o44;
    move_dst   = 6'o13;
    move_valid = 1'b1;
    @(posedge clk);
    #1 move_valid = 1'b0;
    repeat (5) @(negedge clk);
    check_val("arst_in_rem_dst", {remove_piece, figure_position}, {1'b1, 6'o13});
    #2 rst = 1'b1;
    #1;
    check_val("arst_outputs", {move_ready, remove_piece, place_piece, move_done, move_err, captured_valid}, 6'b100000);
    check_val("arst_fig_rd", {figure_position, figure_code, rd_pos}, 0);
    check_val("arst_err_cap", {err_code, captured_code}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("arst_ready_after", move_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
